// File: rtl/johnson_ctrl_pkg.sv
// Shared types and helpers for the Johnson counter sequencing controller:
// FSM state encoding and the legal 4-bit Johnson code set.
package johnson_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    STEP    = 2'b10,
    RECOVER = 2'b11
  } ctrl_state_e;

  localparam int N_LEGAL = 8;

  localparam logic [3:0] LEGAL_CODES [N_LEGAL] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0111,
    4'b1111, 4'b1110, 4'b1100, 4'b1000
  };

  function automatic logic is_legal_johnson(input logic [3:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (code == LEGAL_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_PERIOD-1 while enabled and flags the
// last count, giving one tick every TICK_PERIOD enabled cycles.
module tick_prescaler #(
  parameter int TICK_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  // Decoded from the registered count so the tick is glitch-free and Moore.
  assign tick = enable && (count == LAST);

endmodule

// File: rtl/johnson_seq_controller.sv
// Single-clock sequencer for the Johnson LED counter: issues advance enables
// from a prescaler or a step button and clears the counter on illegal codes.
module johnson_seq_controller
  import johnson_ctrl_pkg::*;
#(
  parameter int TICK_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_sw,
  input  logic       dir_sw,
  input  logic       step_btn,
  input  logic [3:0] cnt_q,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic [1:0] state_out,
  output logic       fault
);

  ctrl_state_e state;
  ctrl_state_e state_nxt;

  logic step_prev;
  logic step_rise;
  logic code_ok;
  logic in_run;
  logic presc_clear;
  logic tick;

  assign code_ok   = is_legal_johnson(cnt_q);
  assign step_rise = step_btn & ~step_prev;
  assign in_run    = (state == RUN);

  // Prescaler restarts from zero on every entry into RUN and on leaving it.
  assign presc_clear = ~in_run | (state_nxt != RUN);

  tick_prescaler #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (in_run),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_prev <= 1'b0;
      cnt_up    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      step_prev <= step_btn;
      cnt_up    <= dir_sw;
      if (state == RECOVER) fault <= 1'b1;
    end
  end

  // Outputs depend only on state and prescaler, so a run_sw drop on the
  // terminal count still lets that cycle's advance through.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (!code_ok)       state_nxt = RECOVER;
        else if (run_sw)    state_nxt = RUN;
        else if (step_rise) state_nxt = STEP;
      end
      RUN: begin
        cnt_en = tick;
        if (!code_ok)     state_nxt = RECOVER;
        else if (!run_sw) state_nxt = IDLE;
      end
      STEP: begin
        cnt_en    = 1'b1;
        state_nxt = IDLE;
      end
      RECOVER: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_johnson_seq_controller.sv
// Closed-loop bench: a behavioural Johnson counter is driven by the controller,
// a cycle model predicts every output, and directed phases pin literal values.
module tb_johnson_seq_controller;

  localparam int TP = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_REC  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_sw = 1'b0;
  logic       dir_sw = 1'b0;
  logic       step_btn = 1'b0;
  logic       force_bad = 1'b0;
  logic [3:0] jc = 4'b0000;
  logic [3:0] cnt_q;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_clr;
  logic [1:0] state_out;
  logic       fault;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign cnt_q = force_bad ? 4'b0101 : jc;

  johnson_seq_controller #(
    .TICK_PERIOD(TP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_sw    (run_sw),
    .dir_sw    (dir_sw),
    .step_btn  (step_btn),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_up    (cnt_up),
    .cnt_clr   (cnt_clr),
    .state_out (state_out),
    .fault     (fault)
  );

  // Johnson counter under control: up shifts left inserting ~msb, down shifts right inserting ~lsb.
  always @(posedge clk) begin
    if (cnt_clr)     jc <= 4'b0000;
    else if (cnt_en) jc <= cnt_up ? {jc[2:0], ~jc[3]} : {~jc[0], jc[3:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A code is legal iff it appears in the 8-step orbit of 0000 under the up-shift.
  function automatic bit m_legal(input logic [3:0] c);
    logic [3:0] v;
    v = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      if (v == c) return 1'b1;
      v = {v[2:0], ~v[3]};
    end
    return 1'b0;
  endfunction

  int  m_mode  = M_IDLE;
  int  run_age = 0;
  bit  m_prev  = 1'b0;
  bit  m_up    = 1'b0;
  bit  m_fault = 1'b0;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode  <= M_IDLE;
      run_age <= 0;
      m_prev  <= 1'b0;
      m_up    <= 1'b0;
      m_fault <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_prev <= step_btn;
      m_up   <= dir_sw;
      if (m_mode == M_REC) m_fault <= 1'b1;
      if (m_mode == M_IDLE) begin
        if (!m_legal(cnt_q))          m_mode <= M_REC;
        else if (run_sw) begin        m_mode <= M_RUN; run_age <= 0; end
        else if (step_btn && !m_prev) m_mode <= M_STEP;
      end else if (m_mode == M_RUN) begin
        if (!m_legal(cnt_q)) m_mode <= M_REC;
        else if (!run_sw)    m_mode <= M_IDLE;
        else                 run_age <= run_age + 1;
      end else begin
        m_mode <= M_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state_out", 32'(state_out), 32'(m_mode));
      chk("cnt_en", 32'(cnt_en),
          32'((m_mode == M_STEP) || (m_mode == M_RUN && (run_age % TP) == TP - 1)));
      chk("cnt_clr", 32'(cnt_clr), 32'(m_mode == M_REC));
      chk("cnt_up", 32'(cnt_up), 32'(m_up));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("en_clr_exclusive", 32'(cnt_en & cnt_clr), 32'(0));
    end
  end

  initial begin
    int first;
    int npulse;
    int last;
    logic [3:0] down_seq [3];
    down_seq[0] = 4'b1000;
    down_seq[1] = 4'b1100;
    down_seq[2] = 4'b1110;

    reset = 1'b1;
    cyc(2);
    chk("rst_state", 32'(state_out), 32'h0);
    chk("rst_en", 32'(cnt_en), 32'h0);
    chk("rst_clr", 32'(cnt_clr), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_up", 32'(cnt_up), 32'h0);
    reset = 1'b0;
    cyc(3);
    chk("idle_cnt_q", 32'(jc), 32'h0);
    chk("idle_state", 32'(state_out), 32'h0);

    // Free run downwards; drop run_sw on the cycle of the fourth pulse.
    run_sw = 1'b1;
    dir_sw = 1'b0;
    first = 0; npulse = 0; last = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (cnt_en) begin
        npulse++;
        last = i;
        if (first == 0) first = i;
      end
      if (i == 5 || i == 9 || i == 13) chk("down_seq", 32'(jc), 32'(down_seq[(i - 5) / 4]));
    end
    chk("run_first", 32'(first), 32'd4);
    chk("run_npulse", 32'(npulse), 32'd4);
    chk("run_last", 32'(last), 32'd16);
    run_sw = 1'b0;
    cyc(1);
    chk("run_end_cnt_q", 32'(jc), 32'hf);
    chk("run_end_state", 32'(state_out), 32'h0);

    // Stop mid-count after two pulses, then re-enter RUN.
    run_sw = 1'b1;
    npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (cnt_en) npulse++;
    end
    chk("stop_npulse", 32'(npulse), 32'd2);
    run_sw = 1'b0;
    cyc(1);
    chk("stop_state", 32'(state_out), 32'h0);
    npulse = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (cnt_en) npulse++;
    end
    chk("stop_quiet", 32'(npulse), 32'd0);
    run_sw = 1'b1;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (cnt_en && first == 0) first = i;
    end
    chk("reenter_first", 32'(first), 32'd4);
    run_sw = 1'b0;
    cyc(2);
    chk("reenter_cnt_q", 32'(jc), 32'h0);

    // Illegal code while running.
    run_sw = 1'b1;
    cyc(2);
    force_bad = 1'b1;
    cyc(1);
    chk("rec_state", 32'(state_out), 32'h3);
    chk("rec_clr", 32'(cnt_clr), 32'h1);
    chk("rec_en", 32'(cnt_en), 32'h0);
    force_bad = 1'b0;
    run_sw = 1'b0;
    cyc(1);
    chk("rec_cnt_q", 32'(jc), 32'h0);
    chk("rec_fault", 32'(fault), 32'h1);
    chk("rec_idle", 32'(state_out), 32'h0);
    cyc(5);
    chk("fault_sticky", 32'(fault), 32'h1);
    reset = 1'b1;
    cyc(1);
    chk("fault_reset", 32'(fault), 32'h0);
    reset = 1'b0;

    // Single step with the button held high.
    dir_sw = 1'b1;
    cyc(1);
    step_btn = 1'b1;
    first = 0; npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (cnt_en) begin
        npulse++;
        if (first == 0) first = i;
      end
    end
    chk("step_npulse", 32'(npulse), 32'd1);
    chk("step_first", 32'(first), 32'd1);
    step_btn = 1'b0;
    cyc(1);
    chk("step_cnt_q", 32'(jc), 32'h1);

    // Reset landing on the STEP cycle.
    step_btn = 1'b1;
    cyc(1);
    chk("abort_step_state", 32'(state_out), 32'h2);
    chk("abort_step_en", 32'(cnt_en), 32'h1);
    reset = 1'b1;
    step_btn = 1'b0;
    cyc(1);
    chk("abort_en", 32'(cnt_en), 32'h0);
    chk("abort_state", 32'(state_out), 32'h0);
    reset = 1'b0;
    cyc(2);
    chk("abort_idle", 32'(state_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
